// File: rtl/configurable_mode_fifo.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read mode,
// programmable almost thresholds, fill level, synchronous flush and sticky error flags.
module configurable_mode_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter bit FWFT_MODE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_accept, rd_accept;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

    // Occupancy comes from the pointer difference; the extra wrap bit separates full from empty.
    assign level        = wr_ptr_q - rd_ptr_q;
    assign empty        = (level == '0);
    assign full         = (level == DEPTH_LVL);
    assign almost_full  = (level >= af_thresh);
    assign almost_empty = (level <= ae_thresh);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_idx    = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_idx    = rd_ptr_q[ADDR_WIDTH-1:0];
    assign wr_accept = wr_en && !full && !flush;
    assign rd_accept = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A fresh error in the clear cycle must survive the clear.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full && !flush)  overflow_d  = 1'b1;
        if (rd_en && empty && !flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_idx] <= wr_data;
    end

    generate
        if (FWFT_MODE) begin : g_fwft
            assign rd_data  = empty ? '0 : mem_q[rd_idx];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
            logic                  rd_valid_q, rd_valid_d;

            // Registered read: data holds between reads, valid pulses once per accepted read.
            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = 1'b0;
                if (flush) begin
                    rd_data_d = '0;
                end else if (rd_accept) begin
                    rd_data_d  = mem_q[rd_idx];
                    rd_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_configurable_mode_fifo.sv
// Drives a standard-mode and a FWFT-mode FIFO with identical stimulus and checks both
// every cycle against a queue-based model, plus directed scenarios with literal expectations.
module tb_configurable_mode_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;
    logic          err_clr;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic [AW:0]   s_level, f_level;
    logic          s_empty, f_empty, s_full, f_full;
    logic          s_ae, f_ae, s_af, f_af;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    int checks = 0;
    int errors = 0;

    configurable_mode_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT_MODE(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .level(s_level), .empty(s_empty),
        .full(s_full), .almost_empty(s_ae), .almost_full(s_af), .overflow(s_ovf),
        .underflow(s_unf)
    );

    configurable_mode_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT_MODE(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .level(f_level), .empty(f_empty),
        .full(f_full), .almost_empty(f_ae), .almost_full(f_af), .overflow(f_ovf),
        .underflow(f_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a plain queue of stored words plus the registered-read output state.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_std_data;
    logic          m_std_valid;
    logic          m_ovf, m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_std_data  = '0;
            m_std_valid = 1'b0;
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
        end else begin
            bit was_full, was_empty, wa, ra;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            wa = wr_en && !was_full && !flush;
            ra = rd_en && !was_empty && !flush;
            m_ovf = (m_ovf && !err_clr) || (wr_en && was_full && !flush);
            m_unf = (m_unf && !err_clr) || (rd_en && was_empty && !flush);
            if (flush) begin
                mq.delete();
                m_std_data  = '0;
                m_std_valid = 1'b0;
            end else begin
                m_std_valid = ra;
                if (ra) begin
                    m_std_data = mq[0];
                    void'(mq.pop_front());
                end
                if (wa) mq.push_back(wr_data);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int sz;
        logic [DW-1:0] head;
        sz   = mq.size();
        head = (sz != 0) ? mq[0] : '0;
        checkOutput("s_level", 32'(s_level), 32'(sz));
        checkOutput("f_level", 32'(f_level), 32'(sz));
        checkOutput("s_empty", 32'(s_empty), 32'(sz == 0));
        checkOutput("f_empty", 32'(f_empty), 32'(sz == 0));
        checkOutput("s_full", 32'(s_full), 32'(sz == DEPTH));
        checkOutput("f_full", 32'(f_full), 32'(sz == DEPTH));
        checkOutput("s_almost_full", 32'(s_af), 32'(sz >= int'(af_thresh)));
        checkOutput("f_almost_full", 32'(f_af), 32'(sz >= int'(af_thresh)));
        checkOutput("s_almost_empty", 32'(s_ae), 32'(sz <= int'(ae_thresh)));
        checkOutput("f_almost_empty", 32'(f_ae), 32'(sz <= int'(ae_thresh)));
        checkOutput("s_overflow", 32'(s_ovf), 32'(m_ovf));
        checkOutput("f_overflow", 32'(f_ovf), 32'(m_ovf));
        checkOutput("s_underflow", 32'(s_unf), 32'(m_unf));
        checkOutput("f_underflow", 32'(f_unf), 32'(m_unf));
        checkOutput("s_rd_data", 32'(s_rd_data), 32'(m_std_data));
        checkOutput("s_rd_valid", 32'(s_rd_valid), 32'(m_std_valid));
        checkOutput("f_rd_data", 32'(f_rd_data), 32'(head));
        checkOutput("f_rd_valid", 32'(f_rd_valid), 32'(sz != 0));
    end

    // One clock of stimulus: inputs applied, edge taken, inputs returned to idle.
    task automatic applyStimulus(input logic wr, input logic [DW-1:0] d, input logic rd,
                                 input logic fl, input logic ec);
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        flush   = fl;
        err_clr = ec;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        rd_en     = 1'b0;
        err_clr   = 1'b0;
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_level", 32'(s_level), 32'd0);
        checkOutput("rst_empty", 32'(s_empty), 32'd1);
        checkOutput("rst_full", 32'(s_full), 32'd0);
        checkOutput("rst_rd_valid", 32'(s_rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(s_rd_data), 32'd0);
        checkOutput("rst_almost_empty", 32'(s_ae), 32'd1);
        checkOutput("rst_almost_full", 32'(s_af), 32'd0);
        rst_n = 1'b1;

        // Fill 0x01..0x10, watching the threshold crossings.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
            checkOutput("fill_level", 32'(s_level), 32'(i));
            checkOutput("fill_almost_empty", 32'(s_ae), 32'(i <= 3));
            checkOutput("fill_almost_full", 32'(s_af), 32'(i >= 12));
        end
        checkOutput("fill_full", 32'(s_full), 32'd1);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_set", 32'(s_ovf), 32'd1);
        checkOutput("ovf_level", 32'(s_level), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_clr", 32'(s_ovf), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("drain_std_data", 32'(s_rd_data), 32'(i));
            checkOutput("drain_std_valid", 32'(s_rd_valid), 32'd1);
            checkOutput("drain_fwft_data", 32'(f_rd_data), (i < 16) ? 32'(i + 1) : 32'd0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("std_valid_pulse", 32'(s_rd_valid), 32'd0);
        checkOutput("std_data_hold", 32'(s_rd_data), 32'h10);

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("unf_set", 32'(s_unf), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("unf_clr_loses", 32'(s_unf), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("unf_clr", 32'(s_unf), 32'd0);

        // Standard-mode read latency at level 3.
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
        checkOutput("lat_level", 32'(s_level), 32'd3);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("lat_std_data", 32'(s_rd_data), 32'hA1);
        checkOutput("lat_std_valid", 32'(s_rd_valid), 32'd1);
        checkOutput("lat_fwft_head", 32'(f_rd_data), 32'hA2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("lat_std_pulse", 32'(s_rd_valid), 32'd0);
        checkOutput("lat_std_hold", 32'(s_rd_data), 32'hA1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("fwft_empty_data", 32'(f_rd_data), 32'd0);
        checkOutput("fwft_empty_valid", 32'(f_rd_valid), 32'd0);

        // FWFT fall-through and pop.
        applyStimulus(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
        checkOutput("fwft_valid", 32'(f_rd_valid), 32'd1);
        checkOutput("fwft_data", 32'(f_rd_data), 32'h5C);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("fwft_pop_empty", 32'(f_empty), 32'd1);
        checkOutput("fwft_pop_data", 32'(f_rd_data), 32'd0);

        // Simultaneous read and write at level 8, then at full.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, DW'(8'h40 + i), 1'b1, 1'b0, 1'b0);
            checkOutput("rw_level", 32'(s_level), 32'd8);
            checkOutput("rw_std_data", 32'(s_rd_data), 32'(8'h30 + i));
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("rw_full", 32'(s_full), 32'd1);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        checkOutput("rw_full_level", 32'(s_level), 32'd15);
        checkOutput("rw_full_ovf", 32'(s_ovf), 32'd1);
        checkOutput("rw_full_data", 32'(s_rd_data), 32'h34);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Flush at level 10 with a concurrent write.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_flush_level", 32'(s_level), 32'd10);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_level", 32'(s_level), 32'd0);
        checkOutput("flush_empty", 32'(s_empty), 32'd1);
        checkOutput("flush_ovf", 32'(s_ovf), 32'd0);
        checkOutput("flush_std_data", 32'(s_rd_data), 32'd0);
        checkOutput("flush_std_valid", 32'(s_rd_valid), 32'd0);

        af_thresh = 5'd0;
        #1;
        checkOutput("af_zero", 32'(s_af), 32'd1);
        af_thresh = 5'd12;

        // Randomised traffic alternating fill-heavy and drain-heavy phases.
        for (int n = 0; n < 3000; n++) begin
            int wp;
            wp = ((n / 200) % 2 == 0) ? 75 : 30;
            if ($urandom_range(0, 19) == 0) af_thresh = AW'(0) + 5'($urandom_range(0, 16));
            if ($urandom_range(0, 19) == 0) ae_thresh = 5'($urandom_range(0, 16));
            if (n == 1500) begin
                rst_n = 1'b0;
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
                rst_n = 1'b1;
            end
            applyStimulus($urandom_range(0, 99) < wp, DW'($urandom),
                          $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 5);
        end
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
